// File: rtl/fpu_normalizer.sv
// rtl/fpu_normalizer.sv - normalizes and rounds a raw adder sum into an IEEE-754 single result
// One operation in flight; NORM does one shift per cycle, ROUND does nearest-even.
`timescale 1ns/1ps
module fpu_normalizer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [8:0]  in_exp,
  input  logic [26:0] in_man,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  localparam logic [4:0] MAX_LEFT_SHIFTS = 5'd24;

  state_t      state, state_n;
  logic        sign_q, sign_n;
  logic [8:0]  exp_q, exp_n;
  logic [26:0] man_q, man_n;
  logic [31:0] result_q, result_n;
  logic [4:0]  shift_cnt, shift_cnt_n;

  logic        round_up;
  logic [23:0] frac_sum;
  logic [9:0]  exp_rounded;

  // man_q[1] is guard, man_q[0] sticky, man_q[2] the frac lsb
  always_comb begin
    round_up    = man_q[1] & (man_q[0] | man_q[2]);
    frac_sum    = {1'b0, man_q[24:2]} + {23'b0, round_up};
    exp_rounded = {1'b0, exp_q} + {9'b0, frac_sum[23]};
  end

  always_comb begin
    state_n     = state;
    sign_n      = sign_q;
    exp_n       = exp_q;
    man_n       = man_q;
    result_n    = result_q;
    shift_cnt_n = shift_cnt;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sign_n      = in_sign;
          exp_n       = in_exp;
          man_n       = in_man;
          shift_cnt_n = 5'd0;
          state_n     = NORM;
        end
      end
      NORM: begin
        if (man_q[26]) begin
          man_n   = {1'b0, man_q[26:2], man_q[1] | man_q[0]};
          exp_n   = exp_q + 9'd1;
          state_n = ROUND;
        end else if (man_q == 27'd0 || (exp_q == 9'd0 && !man_q[25])) begin
          result_n = {sign_q, 31'b0};
          state_n  = DONE;
        end else if (man_q[25]) begin
          state_n = ROUND;
        end else if (exp_q == 9'd1 || shift_cnt == MAX_LEFT_SHIFTS) begin
          // no denormals: underflow or exhausted shift budget flushes to zero
          result_n = {sign_q, 31'b0};
          state_n  = DONE;
        end else begin
          man_n       = man_q << 1;
          exp_n       = exp_q - 9'd1;
          shift_cnt_n = shift_cnt + 5'd1;
        end
      end
      ROUND: begin
        if (exp_rounded >= 10'd255) begin
          result_n = {sign_q, 8'hFF, 23'b0};
        end else begin
          result_n = {sign_q, exp_rounded[7:0], frac_sum[22:0]};
        end
        state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      sign_q    <= 1'b0;
      exp_q     <= 9'd0;
      man_q     <= 27'd0;
      result_q  <= 32'd0;
      shift_cnt <= 5'd0;
    end else begin
      state     <= state_n;
      sign_q    <= sign_n;
      exp_q     <= exp_n;
      man_q     <= man_n;
      result_q  <= result_n;
      shift_cnt <= shift_cnt_n;
    end
  end

  assign out_result = result_q;

endmodule
